sevenseg_scanner: RTL
=====================

Name:
sevenseg_scanner

Overview:
- Downstream consumer of the Avalon-MM PIO output port.
- Takes the packed hex-nibble word that software writes into the PIO and drives a multiplexed common-anode seven-segment display.
- Lights one digit at a time, with programmable on-time and inter-digit blanking dead time (anti-ghosting).
- Latches input once per frame so software writes never tear a displayed frame.

Parameters:
- NUM_DIGITS, 4, number of digits; data_in carries 4*NUM_DIGITS bits, digit 0 in bits [3:0].
- DIGIT_CYCLES, 50000, clk cycles each digit is lit (>=1).
- BLANK_CYCLES, 500, clk cycles all anodes off before each digit (>=1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous, active-low
- data_in  input  4*NUM_DIGITS  packed hex digits from PIO co_out_port
- enable  input  1  1 = scan, 0 = display dark
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- an_n  output  NUM_DIGITS  digit anodes, active-low, one-hot-low when lit
- frame_done  output  1  one-cycle pulse at end of last digit's ACTIVE period

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - seg_n = all 1s, an_n = all 1s, frame_done = 0.
  - state = IDLE, digit index = 0, cycle counter = 0, shadow register = 0.
- All outputs are registered; no combinational path from data_in to the pins.
- FSM states: IDLE, BLANK, ACTIVE.
- IDLE:
  - an_n and seg_n all 1s.
  - enable=1 -> BLANK next cycle, index=0, counter=0.
- BLANK:
  - an_n all 1s, seg_n all 1s.
  - Counts BLANK_CYCLES cycles, then -> ACTIVE.
  - When index==0 on BLANK->ACTIVE, the shadow register captures data_in. This is the frame latch.
- ACTIVE:
  - an_n[index]=0, others 1.
  - seg_n = decode(shadow nibble[index]).
  - Counts DIGIT_CYCLES cycles, then -> BLANK with index+1.
  - index wraps NUM_DIGITS-1 -> 0.
  - frame_done=1 for exactly the cycle after the last ACTIVE cycle of index NUM_DIGITS-1.
- Timing: per-digit period = BLANK_CYCLES+DIGIT_CYCLES; frame period = NUM_DIGITS times that.
- First lit cycle of digit 0 occurs BLANK_CYCLES+1 cycles after enable is sampled high in IDLE.
- Counter and index widths: $clog2 of max count, minimum 1 bit. Counter compares against count-1 and resets to 0 on each state change.
- enable=0 in any state:
  - -> IDLE on the next edge; outputs dark that same edge.
  - index and counter cleared; no frame_done.
  - Re-enable restarts from digit 0, including a fresh latch.
- data_in changes mid-frame: ignored until the next digit-0 latch.
- Decode mapping is full hex 0-F. Active-high values: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. seg_n is the bitwise inverse.
- Reset mid-scan: immediate dark outputs; restart from IDLE.

Optional Feature:
- Macro: SEVENSEG_LZB_EN (leading-zero blanking).
- Defined:
  - At latch time, compute a blank mask. Digit k is blanked if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - A blanked digit's ACTIVE period keeps an_n all 1s and seg_n all 1s, with timing unchanged.
- Undefined: every digit is always lit; no mask logic is generated.

Decomposition:
- Package sevenseg_pkg:
  - scan_state_t enum {IDLE, BLANK, ACTIVE}.
  - localparam SEG_W=7.
  - Constant 16-entry segment table, active-high.
- Sub-module hex_to_7seg:
  - Combinational 4-bit -> 7-bit active-low decoder using the package table.
  - Instantiated once, fed by the muxed shadow nibble; output registered in the scanner.

Test Plan:
All scenarios use NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=1.
- Reset: assert reset_n=0 mid-ACTIVE -> same instant seg_n=7'h7F, an_n=4'hF, frame_done=0; after release with enable=0, outputs stay dark.
- Basic scan: data_in=16'h1234, enable=1 -> 1 blank cycle, then an_n=4'hE with seg_n=7'h19 ('4') for 4 cycles. Next digits follow in order:
  - 4'hD with 7'h30 ('3')
  - 4'hB with 7'h24 ('2')
  - 4'h7 with 7'h79 ('1')
- Frame timing: frame_done pulses exactly once every 20 cycles and is never high for 2 consecutive cycles.
- Tear-free: change data_in to 16'hABCD during digit 1 -> rest of frame still shows 1234; next frame digit 0 shows seg_n=7'h21 ('d').
- Enable drop: enable=0 during digit 2 ACTIVE -> next cycle an_n=4'hF, seg_n=7'h7F; enable=1 again -> first lit digit is digit 0 after 1 blank cycle.
- LZB: data_in=16'h0050 -> with SEVENSEG_LZB_EN, digits 3 and 2 are dark, digit 1 shows 7'h12 ('5'), digit 0 shows 7'h40 ('0'); without the macro, all four digits are lit.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Optional leading-zero blanking is enabled with the SEVENSEG_LZB_EN macro.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } scan_state_t;

  localparam int SEG_W = 7;

  // Active-high segment patterns {g,f,e,d,c,b,a}; entry 0 is the rightmost element
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sevenseg_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_n
);

  // Table lookup, inverted for the common-anode display
  always_comb seg_n = ~SEG_TABLE[nibble];

endmodule

// File: rtl/sevenseg_scanner.sv
// Multiplexed common-anode seven-segment scanner with inter-digit blanking.
// The packed hex word is latched once per frame (at digit 0) so the display
// never tears. Define SEVENSEG_LZB_EN to blank leading zero digits.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    enable,
  output logic [SEG_W-1:0]        seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int MAX_CNT = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [SEG_W-1:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]       an_n_q, an_n_d;
  logic                        frame_done_q, frame_done_d;
  logic                        latch;
  logic                        dig_blank;
  logic [3:0]                  nibble;
  logic [SEG_W-1:0]            dec_seg_n;

`ifdef SEVENSEG_LZB_EN
  logic [NUM_DIGITS-1:0] mask_q, mask_d;

  // Digit k is blanked when it and every higher digit are zero; digit 0 never is
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [NUM_DIGITS-1:0][3:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (d[k] == 4'h0);
      m[k]       = zero_above;
    end
    return m;
  endfunction
`endif

  // State and datapath registers; async reset forces the display dark at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      seg_n_q      <= '1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
`ifdef SEVENSEG_LZB_EN
      mask_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
`ifdef SEVENSEG_LZB_EN
      mask_q       <= mask_d;
`endif
    end
  end

  // Next state: dropping enable always returns to IDLE on the next edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = BLANK;
      BLANK:   if (!enable) state_d = IDLE;
               else if (cnt_q == BLK_LAST) state_d = ACTIVE;
      ACTIVE:  if (!enable) state_d = IDLE;
               else if (cnt_q == DIG_LAST) state_d = BLANK;
      default: state_d = IDLE;
    endcase
  end

  // Counter, digit index, frame latch and end-of-frame pulse
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    latch        = (state_q == BLANK) && (state_d == ACTIVE) && (idx_q == '0);
    shadow_d     = latch ? data_in : shadow_q;
    frame_done_d = 1'b0;
    if (state_d == IDLE || state_d != state_q) cnt_d = '0;
    if (state_d == IDLE) begin
      idx_d = '0;
    end else if (state_q == ACTIVE && state_d == BLANK) begin
      idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      frame_done_d = (idx_q == IDX_LAST);
    end
  end

`ifdef SEVENSEG_LZB_EN
  // Blank mask is recomputed only at the frame latch
  always_comb begin
    mask_d    = latch ? lzb_mask(data_in) : mask_q;
    dig_blank = mask_d[idx_d];
  end
`else
  // Every digit is always lit
  always_comb dig_blank = 1'b0;
`endif

  // Decode from next-cycle values so the registered pins track the state
  always_comb nibble = shadow_d[idx_d];

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg_n)
  );

  // Outputs: dark unless the next state is a lit, unblanked ACTIVE digit
  always_comb begin
    an_n_d  = '1;
    seg_n_d = '1;
    if (state_d == ACTIVE && !dig_blank) begin
      an_n_d[idx_d] = 1'b0;
      seg_n_d       = dec_seg_n;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
